ippcsge_rxframe: RTL and testbench

GMII-side receive frame checker sitting directly downstream of the 1000BASE-X PCS receive stage, consuming its `rxdo`/`rxdvl`/`rxerr` byte stream and its `linkdown` flag. It strips preamble/SFD, delimits frames with SOF/EOF markers, checks CRC-32 and frame length, and reports per-frame status plus saturating good/bad frame counters to the MAC. FCS bytes are passed through; the MAC strips them.

---
 rtl/ippcsge_rxframe_pkg.sv | 61 ++++++
 rtl/ippcsge_rxframe_if.sv | 24 ++
 rtl/ippcsge_crc32_d8.sv | 25 ++
 rtl/ippcsge_rxframe.sv | 169 ++++++++++++++++
 tb/tb_ippcsge_rxframe.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ippcsge_rxframe_pkg.sv
// Shared types and constants for the GMII receive frame checker.
// The 2-stage byte pipeline carries a stage_t per cycle.
package ippcsge_rxframe_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAM,
        DATA,
        DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam logic [3:0]  PCNT_MAX      = 4'd15;

    typedef logic [13:0] len_t;
    localparam len_t LEN_SAT = 14'h3FFF;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       crcerr;
        logic       lenerr;
        logic       err;
    } stage_t;

    function automatic stage_t make_stage(
        input logic       valid,
        input logic [7:0] data,
        input logic       sof,
        input logic       eof,
        input logic       crcerr,
        input logic       lenerr,
        input logic       err
    );
        stage_t s;
        s.valid  = valid;
        s.data   = data;
        s.sof    = sof;
        s.eof    = eof;
        s.crcerr = crcerr;
        s.lenerr = lenerr;
        s.err    = err;
        return s;
    endfunction

    function automatic len_t len_inc(input len_t len);
        return (len == LEN_SAT) ? len : len + 14'd1;
    endfunction

    function automatic logic [15:0] cnt_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

endpackage

// File: rtl/ippcsge_rxframe_if.sv
// GMII receive stream from the PCS (ippcsge_gmii_if) and the delimited
// frame stream towards the MAC (ippcsge_rxframe_if).
interface ippcsge_gmii_if;
    logic [7:0] rxdi;
    logic       rxdvl;
    logic       rxerr;
    logic       linkdown;

    modport master (output rxdi, rxdvl, rxerr, linkdown);
    modport slave  (input  rxdi, rxdvl, rxerr, linkdown);
endinterface

interface ippcsge_rxframe_if;
    logic [7:0] odo;
    logic       odvl;
    logic       osof;
    logic       oeof;
    logic       oerr;
    logic       ocrcerr;
    logic       olenerr;

    modport master (output odo, odvl, osof, oeof, oerr, ocrcerr, olenerr);
    modport slave  (input  odo, odvl, osof, oeof, oerr, ocrcerr, olenerr);
endinterface

// File: rtl/ippcsge_crc32_d8.sv
// Combinational byte-wide step of the reflected CRC-32 LFSR, LSB of the
// byte first, matching Ethernet bit order.
module ippcsge_crc32_d8
    import ippcsge_rxframe_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/ippcsge_rxframe.sv
// GMII receive frame checker: strips preamble/SFD, delimits frames with
// SOF/EOF, checks CRC-32 and length, and keeps saturating frame counters.
module ippcsge_rxframe
    import ippcsge_rxframe_pkg::*;
#(
    parameter int MAXLEN = 1522,
    parameter int MINLEN = 64
) (
    input  logic               rxclk,
    input  logic               rst,
    ippcsge_gmii_if.slave      gmii,
    ippcsge_rxframe_if.master  frame,
    output logic               pream_drop,
    output logic [15:0]        good_cnt,
    output logic [15:0]        bad_cnt
);

    localparam len_t MIN_LEN = 14'(MINLEN);
    localparam len_t MAX_LEN = 14'(MAXLEN);

    rx_state_t   state;
    logic [3:0]  pcnt;
    len_t        len;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic        serr;

    // Stage 1 holds the newest data byte until the next cycle shows
    // whether it was the last one; stage 2 carries the decided status.
    logic        p1_valid;
    logic [7:0]  p1_data;
    logic        p1_first;
    stage_t      p2;

    logic        crc_bad;
    logic        len_bad;
    logic [7:0]  pend_byte;
    logic        pend_sof;
    logic        is_pre;
    logic        is_sfd;

    ippcsge_crc32_d8 u_crc (
        .data     (gmii.rxdi),
        .crc      (crc),
        .crc_next (crc_next)
    );

    assign crc_bad   = (crc != CRC_RESIDUE);
    assign len_bad   = (len < MIN_LEN) || (len > MAX_LEN);
    assign pend_byte = p1_valid ? p1_data : 8'h00;
    assign pend_sof  = p1_valid & p1_first;
    assign is_pre    = gmii.rxdvl && !gmii.rxerr && (gmii.rxdi == PREAMBLE_BYTE);
    assign is_sfd    = gmii.rxdvl && !gmii.rxerr && (gmii.rxdi == SFD_BYTE);

    always_ff @(posedge rxclk) begin
        if (rst) begin
            state         <= WAIT_IDLE;
            pcnt          <= 4'd0;
            len           <= '0;
            crc           <= CRC_INIT;
            serr          <= 1'b0;
            p1_valid      <= 1'b0;
            p1_data       <= 8'h00;
            p1_first      <= 1'b0;
            p2            <= '0;
            pream_drop    <= 1'b0;
            frame.odo     <= 8'h00;
            frame.odvl    <= 1'b0;
            frame.osof    <= 1'b0;
            frame.oeof    <= 1'b0;
            frame.oerr    <= 1'b0;
            frame.ocrcerr <= 1'b0;
            frame.olenerr <= 1'b0;
            good_cnt      <= 16'h0000;
            bad_cnt       <= 16'h0000;
        end else begin
            frame.odo     <= p2.data;
            frame.odvl    <= p2.valid;
            frame.osof    <= p2.sof;
            frame.oeof    <= p2.eof;
            frame.oerr    <= p2.err;
            frame.ocrcerr <= p2.crcerr;
            frame.olenerr <= p2.lenerr;
            if (p2.eof) begin
                if (p2.err) begin
                    bad_cnt <= cnt_inc(bad_cnt);
                end else begin
                    good_cnt <= cnt_inc(good_cnt);
                end
            end

            p2         <= '0;
            pream_drop <= 1'b0;

            case (state)
                WAIT_IDLE: begin
                    if (!gmii.rxdvl && !gmii.linkdown) begin
                        state <= IDLE;
                    end
                end

                IDLE: begin
                    if (gmii.rxdvl) begin
                        if (is_pre) begin
                            state <= PREAM;
                            pcnt  <= 4'd1;
                        end else begin
                            state      <= DROP;
                            pream_drop <= 1'b1;
                        end
                    end
                end

                PREAM: begin
                    if (is_pre && (pcnt != PCNT_MAX)) begin
                        pcnt <= pcnt + 4'd1;
                    end else if (is_sfd) begin
                        state    <= DATA;
                        crc      <= CRC_INIT;
                        len      <= '0;
                        serr     <= 1'b0;
                        p1_valid <= 1'b0;
                    end else begin
                        state      <= DROP;
                        pream_drop <= 1'b1;
                    end
                end

                DATA: begin
                    // Link loss wins over a normal end seen in the same cycle.
                    if (gmii.linkdown) begin
                        p2       <= make_stage(1'b1, pend_byte, pend_sof, 1'b1,
                                               crc_bad, len_bad, 1'b1);
                        p1_valid <= 1'b0;
                        state    <= WAIT_IDLE;
                    end else if (gmii.rxdvl) begin
                        p2       <= make_stage(p1_valid, pend_byte, pend_sof, 1'b0,
                                               1'b0, 1'b0, 1'b0);
                        p1_valid <= 1'b1;
                        p1_data  <= gmii.rxdi;
                        p1_first <= (len == '0);
                        crc      <= crc_next;
                        len      <= len_inc(len);
                        serr     <= serr | gmii.rxerr;
                    end else begin
                        if (p1_valid) begin
                            p2 <= make_stage(1'b1, p1_data, p1_first, 1'b1,
                                             crc_bad, len_bad,
                                             crc_bad | len_bad | serr);
                        end
                        p1_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end

                DROP: begin
                    if (!gmii.rxdvl) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= WAIT_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ippcsge_rxframe.sv
// Directed bench for ippcsge_rxframe: bursts are built with a reference
// FCS, driven on the negative edge, and outputs are collected by a monitor.
module tb_ippcsge_rxframe;
    import ippcsge_rxframe_pkg::*;

    logic        rxclk = 1'b0;
    logic        rst;
    logic        pream_drop;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    ippcsge_gmii_if    gmii ();
    ippcsge_rxframe_if frame ();

    ippcsge_rxframe dut (
        .rxclk      (rxclk),
        .rst        (rst),
        .gmii       (gmii),
        .frame      (frame),
        .pream_drop (pream_drop),
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
    );

    always #4 rxclk = ~rxclk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] fr[$];
    int         first_idx;
    int         mark_idx;
    int         in_edge;
    int         mark_edge;
    logic [47:0] rst_snap;

    int         mon_bytes      = 0;
    int         mon_dv_total   = 0;
    int         mon_eofs       = 0;
    int         mon_stray_eof  = 0;
    int         mon_sof_bad    = 0;
    int         mon_drops      = 0;
    int         mon_drop_edge  = 0;
    int         mon_first_edge = 0;
    int         mon_len        = 0;
    logic [7:0] mon_first_byte = 8'h00;
    logic [7:0] mon_last_byte  = 8'h00;
    logic       mon_err        = 1'b0;
    logic       mon_crcerr     = 1'b0;
    logic       mon_lenerr     = 1'b0;
    logic       mon_eof_sof    = 1'b0;

    always @(posedge rxclk) cyc <= cyc + 1;

    always @(negedge rxclk) begin
        if (pream_drop) begin
            mon_drops     = mon_drops + 1;
            mon_drop_edge = cyc;
        end
        if (frame.odvl) begin
            if (mon_bytes == 0) begin
                mon_first_edge = cyc;
                mon_first_byte = frame.odo;
                if (!frame.osof) mon_sof_bad = mon_sof_bad + 1;
            end else if (frame.osof) begin
                mon_sof_bad = mon_sof_bad + 1;
            end
            mon_bytes    = mon_bytes + 1;
            mon_dv_total = mon_dv_total + 1;
            if (frame.oeof) begin
                mon_eofs      = mon_eofs + 1;
                mon_len       = mon_bytes;
                mon_last_byte = frame.odo;
                mon_err       = frame.oerr;
                mon_crcerr    = frame.ocrcerr;
                mon_lenerr    = frame.olenerr;
                mon_eof_sof   = frame.osof;
                mon_bytes     = 0;
            end
        end else begin
            if (frame.oeof) mon_stray_eof = mon_stray_eof + 1;
            mon_bytes = 0;
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic build_frame(input int npre, input int ndata, input logic [7:0] start,
                               input logic [7:0] step, input bit add_fcs);
        logic [31:0] c;
        logic [7:0]  b;
        fr.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < npre; i++) fr.push_back(8'h55);
        fr.push_back(8'hD5);
        first_idx = npre + 1;
        for (int i = 0; i < ndata; i++) begin
            b = start + 8'(i) * step;
            fr.push_back(b);
            c = crc_byte(c, b);
        end
        if (add_fcs) begin
            for (int k = 0; k < 4; k++) fr.push_back(~c[8*k +: 8]);
        end
    endtask

    task automatic idle(input int n, input logic ld);
        repeat (n) begin
            @(negedge rxclk);
            gmii.rxdvl    = 1'b0;
            gmii.rxerr    = 1'b0;
            gmii.rxdi     = 8'h00;
            gmii.linkdown = ld;
            rst           = 1'b0;
        end
    endtask

    // Drives fr as one burst, then one cycle of rxdvl=0.
    task automatic applyStimulus(input int err_at, input int ld_at, input int rst_at);
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge rxclk);
            if (rst_at >= 0 && i == rst_at + 1) begin
                rst_snap = {frame.odo, frame.odvl, frame.osof, frame.oeof, frame.oerr,
                            frame.ocrcerr, frame.olenerr, pream_drop, good_cnt, bad_cnt};
            end
            gmii.rxdvl    = 1'b1;
            gmii.rxdi     = fr[i];
            gmii.rxerr    = (i == err_at);
            gmii.linkdown = (ld_at >= 0) && (i >= ld_at);
            rst           = (i == rst_at);
            if (i == first_idx) in_edge = cyc + 1;
            if (i == mark_idx) mark_edge = cyc + 1;
        end
        @(negedge rxclk);
        gmii.rxdvl    = 1'b0;
        gmii.rxerr    = 1'b0;
        gmii.rxdi     = 8'h00;
        gmii.linkdown = (ld_at >= 0);
        rst           = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int dv_before;
    int eofs_before;
    logic [7:0] fcs_last;

    initial begin
        rst           = 1'b1;
        gmii.rxdvl    = 1'b0;
        gmii.rxerr    = 1'b0;
        gmii.rxdi     = 8'h00;
        gmii.linkdown = 1'b0;
        mark_idx      = -1;
        first_idx     = -1;
        in_edge       = 0;
        mark_edge     = 0;
        rst_snap      = '1;

        repeat (3) @(negedge rxclk);
        checkOutput("reset_odvl", 64'(frame.odvl), 64'd0);
        checkOutput("reset_odo", 64'(frame.odo), 64'd0);
        checkOutput("reset_eof", 64'(frame.oeof), 64'd0);
        checkOutput("reset_good_cnt", 64'(good_cnt), 64'd0);
        checkOutput("reset_bad_cnt", 64'(bad_cnt), 64'd0);
        checkOutput("reset_pream_drop", 64'(pream_drop), 64'd0);
        rst = 1'b0;
        idle(3, 1'b0);

        $display("[TB] good 64-byte frame");
        build_frame(7, 60, 8'h00, 8'h00, 1'b1);
        fcs_last = fr[fr.size()-1];
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("good_len", 64'(mon_len), 64'd64);
        checkOutput("good_err", 64'({mon_err, mon_crcerr, mon_lenerr}), 64'd0);
        checkOutput("good_last_byte", 64'(mon_last_byte), 64'(fcs_last));
        checkOutput("good_latency", 64'(mon_first_edge), 64'(in_edge + 2));
        checkOutput("good_cnt_1", 64'(good_cnt), 64'd1);
        checkOutput("good_sof_once", 64'(mon_sof_bad), 64'd0);

        $display("[TB] FCS bit flipped");
        build_frame(7, 60, 8'h00, 8'h00, 1'b1);
        fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("crc_flags", 64'({mon_err, mon_crcerr, mon_lenerr}), 64'b110);
        checkOutput("crc_bad_cnt", 64'(bad_cnt), 64'd1);
        checkOutput("crc_good_cnt", 64'(good_cnt), 64'd1);

        $display("[TB] runt 44 bytes");
        build_frame(7, 40, 8'h5A, 8'h03, 1'b1);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("runt_len", 64'(mon_len), 64'd44);
        checkOutput("runt_flags", 64'({mon_err, mon_crcerr, mon_lenerr}), 64'b101);

        $display("[TB] exactly MAXLEN and MAXLEN+1");
        build_frame(7, 1518, 8'h01, 8'h07, 1'b1);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("maxlen_len", 64'(mon_len), 64'd1522);
        checkOutput("maxlen_flags", 64'({mon_err, mon_crcerr, mon_lenerr}), 64'b000);
        build_frame(7, 1519, 8'h01, 8'h07, 1'b1);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("long_len", 64'(mon_len), 64'd1523);
        checkOutput("long_flags", 64'({mon_err, mon_crcerr, mon_lenerr}), 64'b101);
        checkOutput("long_counts", 64'({good_cnt, bad_cnt}), 64'h0002_0003);

        $display("[TB] preamble errors");
        dv_before = mon_dv_total;
        fr.delete();
        fr.push_back(8'h55); fr.push_back(8'h55); fr.push_back(8'h5D);
        fr.push_back(8'h11); fr.push_back(8'h22); fr.push_back(8'h33);
        first_idx = -1;
        mark_idx  = 2;
        applyStimulus(-1, -1, -1);
        idle(3, 1'b0);
        mark_idx = -1;
        checkOutput("drop_5d_pulses", 64'(mon_drops), 64'd1);
        checkOutput("drop_5d_timing", 64'(mon_drop_edge), 64'(mark_edge));
        build_frame(16, 20, 8'h00, 8'h01, 1'b1);
        applyStimulus(-1, -1, -1);
        idle(3, 1'b0);
        checkOutput("drop_16pre_pulses", 64'(mon_drops), 64'd2);
        fr.delete();
        fr.push_back(8'hD5); fr.push_back(8'h55); fr.push_back(8'hD5);
        fr.push_back(8'h01); fr.push_back(8'h02);
        first_idx = -1;
        applyStimulus(-1, -1, -1);
        idle(3, 1'b0);
        checkOutput("drop_sfd_first_pulses", 64'(mon_drops), 64'd3);
        checkOutput("drop_no_output", 64'(mon_dv_total), 64'(dv_before));
        build_frame(15, 60, 8'h00, 8'h00, 1'b1);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("pre15_good", 64'({mon_len, 1'b0, mon_err}), 64'({32'd64, 1'b0, 1'b0}));
        checkOutput("pre15_good_cnt", 64'(good_cnt), 64'd3);

        $display("[TB] link down during data");
        build_frame(7, 60, 8'h10, 8'h01, 1'b1);
        eofs_before = mon_eofs;
        applyStimulus(-1, first_idx + 20, -1);
        idle(3, 1'b1);
        checkOutput("abort_len", 64'(mon_len), 64'd20);
        checkOutput("abort_last_byte", 64'(mon_last_byte), 64'h23);
        checkOutput("abort_err", 64'(mon_err), 64'd1);
        checkOutput("abort_bad_cnt", 64'(bad_cnt), 64'd4);
        dv_before   = mon_dv_total;
        eofs_before = mon_eofs;
        build_frame(7, 60, 8'h00, 8'h00, 1'b1);
        applyStimulus(-1, -1, -1);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("recover_dv", 64'(mon_dv_total), 64'(dv_before + 64));
        checkOutput("recover_eofs", 64'(mon_eofs), 64'(eofs_before + 1));
        checkOutput("recover_good_cnt", 64'(good_cnt), 64'd4);

        $display("[TB] rxerr on data byte 30");
        build_frame(7, 60, 8'h20, 8'h05, 1'b1);
        applyStimulus(first_idx + 30, -1, -1);
        idle(4, 1'b0);
        checkOutput("serr_flags", 64'({mon_err, mon_crcerr, mon_lenerr}), 64'b100);
        checkOutput("serr_bad_cnt", 64'(bad_cnt), 64'd5);

        $display("[TB] one-byte frame");
        build_frame(7, 1, 8'hAB, 8'h00, 1'b0);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("one_len", 64'(mon_len), 64'd1);
        checkOutput("one_byte", 64'(mon_first_byte), 64'hAB);
        checkOutput("one_sof_eof", 64'(mon_eof_sof), 64'd1);
        checkOutput("one_flags", 64'({mon_err, mon_crcerr, mon_lenerr}), 64'b111);

        $display("[TB] back-to-back frames");
        dv_before   = mon_dv_total;
        eofs_before = mon_eofs;
        build_frame(7, 60, 8'h33, 8'h11, 1'b1);
        applyStimulus(-1, -1, -1);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("b2b_dv", 64'(mon_dv_total), 64'(dv_before + 128));
        checkOutput("b2b_eofs", 64'(mon_eofs), 64'(eofs_before + 2));
        checkOutput("b2b_counts", 64'({good_cnt, bad_cnt}), 64'h0006_0006);

        $display("[TB] reset mid-frame");
        build_frame(7, 60, 8'h40, 8'h01, 1'b1);
        eofs_before = mon_eofs;
        applyStimulus(-1, -1, first_idx + 30);
        dv_before = mon_dv_total;
        idle(4, 1'b0);
        checkOutput("midrst_outputs", 64'(rst_snap), 64'd0);
        checkOutput("midrst_no_more_dv", 64'(mon_dv_total), 64'(dv_before));
        checkOutput("midrst_no_eof", 64'(mon_eofs), 64'(eofs_before));
        checkOutput("midrst_counts", 64'({good_cnt, bad_cnt}), 64'd0);

        $display("[TB] good_cnt saturation");
        @(negedge rxclk);
        force dut.good_cnt = 16'hFFFE;
        @(negedge rxclk);
        release dut.good_cnt;
        build_frame(7, 60, 8'h00, 8'h00, 1'b1);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("sat_reach", 64'(good_cnt), 64'hFFFF);
        applyStimulus(-1, -1, -1);
        idle(4, 1'b0);
        checkOutput("sat_hold", 64'(good_cnt), 64'hFFFF);
        checkOutput("sat_bad_cnt", 64'(bad_cnt), 64'd0);

        checkOutput("stray_eof", 64'(mon_stray_eof), 64'd0);
        checkOutput("sof_placement", 64'(mon_sof_bad), 64'd0);
        checkOutput("total_drops", 64'(mon_drops), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
